// File: rtl/noc_credit_link.sv
// noc_credit_link: bundle of credit-flow-controlled NoC links. Each channel has
// a registered forward flit path, a matching reverse credit path, a credit
// accounting monitor with sticky error flags and a packet-framing tracker.
// Monitors only observe; forwarded traffic is never altered.
module noc_credit_link #(
  parameter int NUM_CHANNELS      = 4,
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                     clk_noc,
  input  logic                                     rst_noc,
  input  logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  data_in,
  input  logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  dest_in,
  input  logic [NUM_CHANNELS-1:0]                  is_tail_in,
  input  logic [NUM_CHANNELS-1:0]                  send_in,
  output logic [NUM_CHANNELS-1:0]                  credit_out,
  output logic [NUM_CHANNELS-1:0][FLIT_WIDTH-1:0]  data_out,
  output logic [NUM_CHANNELS-1:0][DEST_WIDTH-1:0]  dest_out,
  output logic [NUM_CHANNELS-1:0]                  is_tail_out,
  output logic [NUM_CHANNELS-1:0]                  send_out,
  input  logic [NUM_CHANNELS-1:0]                  credit_in,
  output logic [NUM_CHANNELS-1:0][CREDIT_WIDTH-1:0] credit_count,
  output logic [NUM_CHANNELS-1:0]                  pkt_active,
  output logic [NUM_CHANNELS-1:0]                  err_overflow,
  output logic [NUM_CHANNELS-1:0]                  err_underflow,
  input  logic [NUM_CHANNELS-1:0]                  err_clear
);

  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
    logic                  send;
  } flit_t;

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} frame_state_t;

  flit_t [NUM_CHANNELS-1:0] flit_in;
  flit_t [NUM_CHANNELS-1:0] flit_out;

  // Bundle the per-channel flit fields so the pipeline moves them as one word.
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      flit_in[ch].data = data_in[ch];
      flit_in[ch].dest = dest_in[ch];
      flit_in[ch].tail = is_tail_in[ch];
      flit_in[ch].send = send_in[ch];
    end
  end

  // Forward flit and reverse credit delay lines; zero stages is a plain wire.
  if (NUM_PIPELINE == 0) begin : g_bypass
    assign flit_out   = flit_in;
    assign credit_out = credit_in;
  end else begin : g_pipe
    flit_t [NUM_CHANNELS-1:0] flit_q   [NUM_PIPELINE];
    logic  [NUM_CHANNELS-1:0] credit_q [NUM_PIPELINE];

    // Shift flits and credits one stage per cycle; reset drops everything in flight.
    // NOTE: these stages are ordinary flops that must read 0 after reset, so they
    // are reset element by element; this is not a RAM and gains nothing by skipping it.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
        for (int s = 0; s < NUM_PIPELINE; s++) begin
          flit_q[s]   <= '0;
          credit_q[s] <= '0;
        end
      end else begin
        // NOTE: <= makes every stage capture its predecessor's old value, giving
        // a true shift; = here would collapse the whole chain into one cycle.
        flit_q[0]   <= flit_in;
        credit_q[0] <= credit_in;
        for (int s = 1; s < NUM_PIPELINE; s++) begin
          flit_q[s]   <= flit_q[s-1];
          credit_q[s] <= credit_q[s-1];
        end
      end
    end

    assign flit_out   = flit_q[NUM_PIPELINE-1];
    assign credit_out = credit_q[NUM_PIPELINE-1];
  end

  // Unbundle the delayed flit back onto the downstream ports.
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      data_out[ch]    = flit_out[ch].data;
      dest_out[ch]    = flit_out[ch].dest;
      is_tail_out[ch] = flit_out[ch].tail;
      send_out[ch]    = flit_out[ch].send;
    end
  end

  logic [NUM_CHANNELS-1:0][CREDIT_WIDTH-1:0] count_d;
  logic [NUM_CHANNELS-1:0] ovf_evt, unf_evt, ovf_d, unf_d;

  // Credit accounting at the upstream side: a send consumes, a returned credit
  // refunds, both together cancel. Out-of-range moves saturate and flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    count_d = credit_count;
    ovf_evt = '0;
    unf_evt = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case ({send_in[ch], credit_out[ch]})
        2'b10: begin
          if (credit_count[ch] == '0) ovf_evt[ch] = 1'b1;
          else                        count_d[ch] = credit_count[ch] - 1'b1;
        end
        2'b01: begin
          if (credit_count[ch] == DEPTH_C) unf_evt[ch] = 1'b1;
          else                             count_d[ch] = credit_count[ch] + 1'b1;
        end
        default: ;
      endcase
    end
    // A fresh error event beats a simultaneous clear.
    ovf_d = ovf_evt | (err_overflow  & ~err_clear);
    unf_d = unf_evt | (err_underflow & ~err_clear);
  end

  // Credit counters and sticky error flags.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credit_count  <= {NUM_CHANNELS{DEPTH_C}};
      err_overflow  <= '0;
      err_underflow <= '0;
    end else begin
      credit_count  <= count_d;
      err_overflow  <= ovf_d;
      err_underflow <= unf_d;
    end
  end

  frame_state_t [NUM_CHANNELS-1:0] state_q, state_d;

  // Framing state register per channel.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing next state: a non-tail send opens a packet, a tail send closes it.
  always_comb begin
    state_d    = state_q;
    pkt_active = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      pkt_active[ch] = (state_q[ch] == BODY);
      case (state_q[ch])
        IDLE:    if (send_in[ch] && !is_tail_in[ch]) state_d[ch] = BODY;
        BODY:    if (send_in[ch] &&  is_tail_in[ch]) state_d[ch] = IDLE;
        default: state_d[ch] = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_credit_link.sv
// Self-checking bench for noc_credit_link: a reference model updated at stimulus
// time pushes expectations into queues; a negedge monitor pops and compares.
module tb_noc_credit_link;

  localparam int NC = 4;
  localparam int FW = 64;
  localparam int DW = 4;
  localparam int NP = 2;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic clk_noc = 1'b0;
  logic rst_noc;
  logic [NC-1:0][FW-1:0] data_in, data_out, data_out0;
  logic [NC-1:0][DW-1:0] dest_in, dest_out, dest_out0;
  logic [NC-1:0] is_tail_in, send_in, credit_in, err_clear;
  logic [NC-1:0] credit_out, is_tail_out, send_out, pkt_active, err_overflow, err_underflow;
  logic [NC-1:0] credit_out0, is_tail_out0, send_out0, pkt_active0, err_overflow0, err_underflow0;
  logic [NC-1:0][CW-1:0] credit_count, credit_count0;

  noc_credit_link #(.NUM_CHANNELS(NC), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                    .NUM_PIPELINE(NP), .FLIT_BUFFER_DEPTH(DEPTH)) u_dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .pkt_active(pkt_active), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_clear(err_clear));

  noc_credit_link #(.NUM_CHANNELS(NC), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                    .NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH)) u_dut0 (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out0),
    .data_out(data_out0), .dest_out(dest_out0), .is_tail_out(is_tail_out0),
    .send_out(send_out0), .credit_in(credit_in), .credit_count(credit_count0),
    .pkt_active(pkt_active0), .err_overflow(err_overflow0),
    .err_underflow(err_underflow0), .err_clear(err_clear));

  always #5 clk_noc = ~clk_noc;

  int cyc = 0;
  always @(posedge clk_noc) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic        tail;
  } fexp_t;
  typedef struct {
    int          due;
    logic [NC-1:0] vec;
  } cexp_t;
  typedef struct {
    int          due;
    int          cnt [NC];
    logic [NC-1:0] ovf, unf, act;
  } sexp_t;

  fexp_t fq [NC][$];
  cexp_t cq [$];
  sexp_t sq [$];

  // Reference model: credit balance, sticky flags, in-packet bit, credit history.
  int            m_cnt [NC];
  logic [NC-1:0] m_ovf, m_unf, m_act;
  logic [NC-1:0] cred_hist [$];

  task automatic model_reset();
    for (int ch = 0; ch < NC; ch++) begin
      m_cnt[ch] = DEPTH;
      fq[ch].delete();
    end
    m_ovf = '0; m_unf = '0; m_act = '0;
    cq.delete(); sq.delete(); cred_hist.delete();
    for (int i = 0; i < NP; i++) cred_hist.push_back('0);
  endtask

  task automatic idle();
    data_in = '0; dest_in = '0; is_tail_in = '0; send_in = '0;
    credit_in = '0; err_clear = '0;
  endtask

  // Apply the current inputs for one cycle, updating the model and scoreboard.
  task automatic step();
    logic [NC-1:0] mco;
    fexp_t f;
    cexp_t c;
    sexp_t s;
    bit ev_o, ev_u;
    mco = cred_hist.pop_front();
    cred_hist.push_back(credit_in);
    c.due = cyc + NP; c.vec = credit_in;
    cq.push_back(c);
    for (int ch = 0; ch < NC; ch++) begin
      if (send_in[ch]) begin
        f.due = cyc + NP; f.data = data_in[ch]; f.dest = dest_in[ch]; f.tail = is_tail_in[ch];
        fq[ch].push_back(f);
      end
      ev_o = send_in[ch] && !mco[ch] && (m_cnt[ch] == 0);
      ev_u = mco[ch] && !send_in[ch] && (m_cnt[ch] == DEPTH);
      if (send_in[ch] && !mco[ch] && m_cnt[ch] > 0) m_cnt[ch] = m_cnt[ch] - 1;
      if (mco[ch] && !send_in[ch] && m_cnt[ch] < DEPTH) m_cnt[ch] = m_cnt[ch] + 1;
      m_ovf[ch] = ev_o | (m_ovf[ch] & ~err_clear[ch]);
      m_unf[ch] = ev_u | (m_unf[ch] & ~err_clear[ch]);
      if (send_in[ch]) m_act[ch] = !is_tail_in[ch];
      s.cnt[ch] = m_cnt[ch];
    end
    s.due = cyc + 1; s.ovf = m_ovf; s.unf = m_unf; s.act = m_act;
    sq.push_back(s);
    @(posedge clk_noc); #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_noc = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: compare whatever the DUT presents against queued expectations.
  always @(negedge clk_noc) begin : monitor
    fexp_t f;
    cexp_t c;
    sexp_t s;
    bit exp_send;
    if (mon_en) begin
      for (int ch = 0; ch < NC; ch++) begin
        exp_send = (fq[ch].size() > 0) && (fq[ch][0].due == cyc);
        check($sformatf("send_out[%0d]", ch), 64'(send_out[ch]), 64'(exp_send));
        if (exp_send) begin
          f = fq[ch].pop_front();
          check($sformatf("data_out[%0d]", ch), data_out[ch], f.data);
          check($sformatf("dest_out[%0d]", ch), 64'(dest_out[ch]), 64'(f.dest));
          check($sformatf("is_tail_out[%0d]", ch), 64'(is_tail_out[ch]), 64'(f.tail));
        end
        check($sformatf("np0 data_out[%0d]", ch), data_out0[ch], data_in[ch]);
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        c = cq.pop_front();
        check("credit_out", 64'(credit_out), 64'(c.vec));
      end else begin
        check("credit_out idle", 64'(credit_out), 64'(0));
      end
      if (sq.size() > 0 && sq[0].due == cyc) begin
        s = sq.pop_front();
        for (int ch = 0; ch < NC; ch++)
          check($sformatf("credit_count[%0d]", ch), 64'(credit_count[ch]), 64'(s.cnt[ch]));
        check("err_overflow", 64'(err_overflow), 64'(s.ovf));
        check("err_underflow", 64'(err_underflow), 64'(s.unf));
        check("pkt_active", 64'(pkt_active), 64'(s.act));
      end
      check("np0 send_out", 64'(send_out0), 64'(send_in));
      check("np0 credit_out", 64'(credit_out0), 64'(credit_in));
      check("np0 is_tail_out", 64'(is_tail_out0), 64'(is_tail_in));
    end
  end

  initial begin
    rst_noc = 1'b1;
    idle();
    model_reset();
    repeat (3) @(posedge clk_noc);
    #1;
    for (int ch = 0; ch < NC; ch++)
      check($sformatf("reset credit_count[%0d]", ch), 64'(credit_count[ch]), 64'(DEPTH));
    check("reset send_out", 64'(send_out), 64'(0));
    check("reset credit_out", 64'(credit_out), 64'(0));
    check("reset pkt_active", 64'(pkt_active), 64'(0));
    check("reset err_overflow", 64'({err_overflow, err_underflow}), 64'(0));
    rst_noc = 1'b0;
    mon_en = 1'b1;

    // Latency: flit and credit each take NP cycles.
    idle();
    send_in[0] = 1'b1; data_in[0] = 64'hA5; dest_in[0] = 4'd3; is_tail_in[0] = 1'b1;
    step();
    idle();
    check("lat send t+1", 64'(send_out[0]), 64'(0));
    step();
    check("lat send t+2", 64'(send_out[0]), 64'(1));
    check("lat data t+2", data_out[0], 64'hA5);
    check("lat dest t+2", 64'(dest_out[0]), 64'(3));
    step();
    check("lat send t+3", 64'(send_out[0]), 64'(0));
    credit_in[0] = 1'b1;
    step();
    idle();
    check("lat credit t+1", 64'(credit_out[0]), 64'(0));
    step();
    check("lat credit t+2", 64'(credit_out[0]), 64'(1));
    step();
    check("lat credit t+3", 64'(credit_out[0]), 64'(0));
    step();

    // Credit drain to zero, then overflow and clear.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      send_in[0] = 1'b1; is_tail_in[0] = 1'b1; data_in[0] = {$urandom, $urandom};
      step();
      check("drain count", 64'(credit_count[0]), 64'(DEPTH - 1 - i));
    end
    step();
    check("overflow count", 64'(credit_count[0]), 64'(0));
    check("overflow flag", 64'(err_overflow[0]), 64'(1));
    idle();
    err_clear[0] = 1'b1;
    step();
    idle();
    check("overflow cleared", 64'(err_overflow[0]), 64'(0));

    // Simultaneous send and credit leave the count unchanged.
    credit_in[0] = 1'b1;
    repeat (5) step();
    idle();
    repeat (2) step();
    check("refill count", 64'(credit_count[0]), 64'(5));
    credit_in[0] = 1'b1;
    step();
    idle();
    step();
    send_in[0] = 1'b1; is_tail_in[0] = 1'b1;
    step();
    idle();
    check("send+credit count", 64'(credit_count[0]), 64'(5));

    // Underflow at full balance.
    credit_in[0] = 1'b1;
    repeat (3) step();
    idle();
    repeat (2) step();
    check("full count", 64'(credit_count[0]), 64'(DEPTH));
    credit_in[0] = 1'b1;
    step();
    idle();
    repeat (2) step();
    check("underflow flag", 64'(err_underflow[0]), 64'(1));
    check("underflow count", 64'(credit_count[0]), 64'(DEPTH));
    err_clear[0] = 1'b1;
    step();
    idle();

    // Framing on ch1: head, body, tail, then a single-flit packet.
    check("frame t", 64'(pkt_active[1]), 64'(0));
    send_in[1] = 1'b1; is_tail_in[1] = 1'b0;
    step();
    check("frame t+1", 64'(pkt_active[1]), 64'(1));
    step();
    check("frame t+2", 64'(pkt_active[1]), 64'(1));
    is_tail_in[1] = 1'b1;
    step();
    check("frame t+3", 64'(pkt_active[1]), 64'(0));
    step();
    idle();
    check("frame single", 64'(pkt_active[1]), 64'(0));

    // Overflow on ch2 must not disturb its neighbours.
    send_in[2] = 1'b1; is_tail_in[2] = 1'b1;
    repeat (DEPTH + 1) step();
    idle();
    check("indep ovf", 64'(err_overflow), 64'(4'b0100));
    check("indep unf", 64'(err_underflow), 64'(0));
    check("indep cnt0", 64'(credit_count[0]), 64'(DEPTH));
    check("indep cnt1", 64'(credit_count[1]), 64'(DEPTH - 4));
    check("indep cnt2", 64'(credit_count[2]), 64'(0));
    check("indep cnt3", 64'(credit_count[3]), 64'(DEPTH));
    err_clear = '1;
    step();

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      for (int ch = 0; ch < NC; ch++) begin
        data_in[ch]    = {$urandom, $urandom};
        dest_in[ch]    = DW'($urandom);
        is_tail_in[ch] = ($urandom_range(0, 2) == 0);
        send_in[ch]    = ($urandom_range(0, 9) < 6);
        credit_in[ch]  = ($urandom_range(0, 1) == 1);
        err_clear[ch]  = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    // Asynchronous reset in the middle of a packet.
    do_reset();
    send_in[0] = 1'b1; is_tail_in[0] = 1'b0;
    repeat (5) step();
    idle();
    check("pre-reset count", 64'(credit_count[0]), 64'(3));
    check("pre-reset active", 64'(pkt_active[0]), 64'(1));
    mon_en = 1'b0;
    @(negedge clk_noc);
    rst_noc = 1'b1;
    #1;
    check("async send_out", 64'(send_out), 64'(0));
    check("async count", 64'(credit_count[0]), 64'(DEPTH));
    check("async active", 64'(pkt_active), 64'(0));
    check("async flags", 64'({err_overflow, err_underflow}), 64'(0));
    model_reset();
    @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int ch = 0; ch < NC; ch++) begin
        data_in[ch]    = {$urandom, $urandom};
        is_tail_in[ch] = ($urandom_range(0, 1) == 0);
        send_in[ch]    = ($urandom_range(0, 1) == 0);
        credit_in[ch]  = ($urandom_range(0, 1) == 0);
      end
      step();
    end

    // Drain and confirm every expected flit was delivered.
    idle();
    repeat (NP + 2) step();
    for (int ch = 0; ch < NC; ch++)
      check($sformatf("undelivered[%0d]", ch), 64'(fq[ch].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_credit_link.md
# noc_credit_link

Parametrised multi-channel NoC link stage between adjacent routers, or between a router and its endpoint shim. It carries a bundle of NUM_CHANNELS credit-flow-controlled links, each with NUM_PIPELINE register stages on the forward flit path and the same number on the reverse credit path. Each channel also has a credit-accounting monitor and a packet-framing tracker. Protocol errors are reported through sticky flags without altering traffic. It supersedes the single-link, fixed-depth pipeline link.

## Interface
- NUM_CHANNELS, 4, independent links in the bundle (1..8)
- FLIT_WIDTH, 64, flit payload bits
- DEST_WIDTH, 4, destination field bits
- NUM_PIPELINE, 1, register stages per direction (0..4); 0 = combinational passthrough
- FLIT_BUFFER_DEPTH, 8, downstream input-buffer depth; initial credit count
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), counter width
- clk_noc  in  1  NoC clock; single clock domain
- rst_noc  in  1  reset, asynchronous, active-high
- data_in  in  [NUM_CHANNELS][FLIT_WIDTH]  upstream flit
- dest_in  in  [NUM_CHANNELS][DEST_WIDTH]  upstream destination
- is_tail_in  in  [NUM_CHANNELS]  last flit of packet
- send_in  in  [NUM_CHANNELS]  flit valid
- credit_out  out  [NUM_CHANNELS]  credit returned to upstream
- data_out, dest_out, is_tail_out, send_out  out  same widths  delayed flit to downstream
- credit_in  in  [NUM_CHANNELS]  credit from downstream
- credit_count  out  [NUM_CHANNELS][CREDIT_WIDTH]  credits available to upstream
- pkt_active  out  [NUM_CHANNELS]  channel is mid-packet
- err_overflow  out  [NUM_CHANNELS]  sticky: send with zero credits
- err_underflow  out  [NUM_CHANNELS]  sticky: credit returned beyond depth
- err_clear  in  [NUM_CHANNELS]  synchronous clear of both sticky flags

## Operation
- Forward path: {data, dest, is_tail, send} shifts through NUM_PIPELINE registers per channel. Data registers load every cycle; there is no gating by send.
- Reverse path: credit_in shifts through NUM_PIPELINE single-bit registers and drives credit_out.
- Credit monitor, per channel, sampled at the upstream side using send_in and credit_out:
  - send only: count−1
  - credit only: count+1
  - both, or neither: count unchanged
- Overflow: send_in=1 while count==0 and no credit_out that cycle. Count holds at 0 and err_overflow sets.
- Underflow: credit_out=1 while count==FLIT_BUFFER_DEPTH and no send_in that cycle. Count holds at DEPTH and err_underflow sets.
- Framing FSM, per channel, sampled on send_in:
  - IDLE → BODY on send without tail.
  - BODY → IDLE on send with tail.
  - Send with tail in IDLE (single-flit packet) stays IDLE.
  - pkt_active = (state==BODY).
- err_clear clears both flags. If an error event coincides with err_clear, the event wins and the flag stays 1.
- The monitor and FSM never modify forwarded traffic; channels are fully independent.

## Timing
- rst_noc asserted (async):
  - All pipeline registers clear to 0, so send_out, credit_out, data_out, dest_out and is_tail_out read 0 for NUM_PIPELINE>0.
  - credit_count = FLIT_BUFFER_DEPTH.
  - FSM = IDLE.
  - Error flags = 0.
- Reset mid-operation discards in-flight flits and credits. No partial state survives.
- Forward latency: send_in at cycle t appears on send_out at t+NUM_PIPELINE. Credit latency is identical.
- NUM_PIPELINE=0: outputs equal inputs combinationally. In that case reset affects only the counter, FSM and flags.
- credit_count, pkt_active and flags are registered: they reflect events of cycle t at t+1.
- Full throughput: one flit and one credit per channel per cycle, no bubbles.

## Test plan
- Latency: NUM_PIPELINE=2, send flit data=0xA5 dest=3 on ch0 at cycle 10 → send_out[0]=1 with data 0xA5 dest 3 at cycle 12 only. Credit pulse at cycle 20 → credit_out[0] at cycle 22.
- Credit drain: depth 8, 8 back-to-back sends with no credits → count 7..0. A 9th send sets err_overflow[0] and count stays 0. err_clear → flag 0 next cycle.
- Simultaneous events: count=5, send_in and credit_out high in the same cycle → count stays 5. Count=8 with a credit and no send → err_underflow, count 8.
- Framing: ch1 head, body, tail → pkt_active 0,1,1,0 across cycles t..t+3. A single-flit tail-only packet leaves pkt_active at 0.
- Channel independence: error on ch2 → ch0, ch1 and ch3 counts and flags unchanged. NUM_PIPELINE=0 → outputs track inputs in the same cycle.
- Async reset mid-packet: assert rst_noc at mid-cycle while ch0 is in BODY with count 3 → immediate send_out=0, count=8, pkt_active=0, flags 0.
